// File: rtl/mv_filter_seq.sv
// mv_filter_seq: measurement sequencer for a bank of majority-vote filters.
// One start runs clear -> settle -> prescaled sample strobes -> evaluation,
// then the captured filter decisions are offered on a valid/ready port.
// Optional build macro MV_FILTER_SEQ_AUTO_RESTART_EN: after each accepted
// result the next measurement starts immediately with the latched config.
module mv_filter_seq #(
    parameter int NumChan     = 8,
    parameter int PrescWidth  = 8,
    parameter int WinWidth    = 4,
    parameter int SettleWidth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [PrescWidth-1:0]  cfg_presc_i,
    input  logic [WinWidth-1:0]    cfg_window_i,
    input  logic [SettleWidth-1:0] cfg_settle_i,
    output logic                   filt_sample_o,
    output logic                   filt_clear_o,
    input  logic [NumChan-1:0]     filt_q_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [NumChan-1:0]     res_data_o,
    output logic                   busy_o,
    output logic                   start_drop_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [PrescWidth-1:0]  presc_cfg_q, presc_cfg_d;
    logic [WinWidth-1:0]    win_cfg_q, win_cfg_d;
    logic [SettleWidth-1:0] settle_cfg_q, settle_cfg_d;
    logic [PrescWidth-1:0]  presc_cnt_q, presc_cnt_d;
    logic [WinWidth-1:0]    win_cnt_q, win_cnt_d;
    logic [SettleWidth-1:0] settle_cnt_q, settle_cnt_d;
    logic                   eval_cnt_q, eval_cnt_d;
    logic [NumChan-1:0]     res_data_q, res_data_d;

    logic                   running;
    logic                   strobe;
    logic [WinWidth-1:0]    win_last;
    logic [SettleWidth-1:0] settle_last;

    // Window 0 behaves as 1; terminating on W-1 keeps the counter in range.
    assign win_last    = (win_cfg_q == '0) ? '0 : win_cfg_q - WinWidth'(1);
    assign settle_last = settle_cfg_q - SettleWidth'(1);
    assign running     = (state_q != ST_IDLE);
    assign strobe      = (state_q == ST_SAMPLE) && (presc_cnt_q == presc_cfg_q);

    // Abort wins over a strobe so sample and clear never overlap.
    assign filt_sample_o = strobe && !abort_i;
    assign filt_clear_o  = (state_q == ST_CLEAR) || (abort_i && running);
    assign res_valid_o   = (state_q == ST_OUT);
    assign res_data_o    = res_data_q;
    assign busy_o        = running;
    assign start_drop_o  = start_i && running;

    // Next-state and counter logic for the measurement sequence.
    always_comb begin
        state_d      = state_q;
        presc_cfg_d  = presc_cfg_q;
        win_cfg_d    = win_cfg_q;
        settle_cfg_d = settle_cfg_q;
        presc_cnt_d  = presc_cnt_q;
        win_cnt_d    = win_cnt_q;
        settle_cnt_d = settle_cnt_q;
        eval_cnt_d   = eval_cnt_q;
        res_data_d   = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    presc_cfg_d  = cfg_presc_i;
                    win_cfg_d    = cfg_window_i;
                    settle_cfg_d = cfg_settle_i;
                    presc_cnt_d  = '0;
                    win_cnt_d    = '0;
                    settle_cnt_d = '0;
                    eval_cnt_d   = 1'b0;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = (settle_cfg_q != '0) ? ST_SETTLE : ST_SAMPLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == settle_last) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SettleWidth'(1);
                end
            end
            ST_SAMPLE: begin
                if (strobe) begin
                    presc_cnt_d = '0;
                    if (win_cnt_q == win_last) begin
                        eval_cnt_d = 1'b0;
                        state_d    = ST_EVAL;
                    end else begin
                        win_cnt_d = win_cnt_q + WinWidth'(1);
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + PrescWidth'(1);
                end
            end
            ST_EVAL: begin
                // Two cycles let the filters update and register their output.
                if (eval_cnt_q) begin
                    res_data_d = filt_q_i;
                    state_d    = ST_OUT;
                end else begin
                    eval_cnt_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (res_ready_i) begin
`ifdef MV_FILTER_SEQ_AUTO_RESTART_EN
                    presc_cnt_d  = '0;
                    win_cnt_d    = '0;
                    settle_cnt_d = '0;
                    eval_cnt_d   = 1'b0;
                    state_d      = ST_CLEAR;
`else
                    state_d      = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards any pending result and outranks handshake and start.
        if (abort_i && running) begin
            state_d      = ST_IDLE;
            presc_cnt_d  = '0;
            win_cnt_d    = '0;
            settle_cnt_d = '0;
            eval_cnt_d   = 1'b0;
        end
    end

    // State, latched config, counters and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            presc_cfg_q  <= '0;
            win_cfg_q    <= '0;
            settle_cfg_q <= '0;
            presc_cnt_q  <= '0;
            win_cnt_q    <= '0;
            settle_cnt_q <= '0;
            eval_cnt_q   <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            presc_cfg_q  <= presc_cfg_d;
            win_cfg_q    <= win_cfg_d;
            settle_cfg_q <= settle_cfg_d;
            presc_cnt_q  <= presc_cnt_d;
            win_cnt_q    <= win_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            eval_cnt_q   <= eval_cnt_d;
            res_data_q   <= res_data_d;
        end
    end

endmodule
